// File: rtl/pwm_reg_bank.sv
// PWM register bank: SPI-written configuration registers, combinational readback,
// and CHANNELS double-buffered PWM generators sharing one prescaler.
`timescale 1ns/1ps
module pwm_reg_bank #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [6:0]          wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic [6:0]          rd_addr,
    output logic [WIDTH-1:0]    rd_data,
    output logic [CHANNELS-1:0] pwm_out,
    output logic [CHANNELS-1:0] period_end
);

    logic [CHANNELS-1:0] enable;
    logic [WIDTH-1:0]    prescale;
    logic [WIDTH-1:0]    pcnt;
    logic [WIDTH-1:0]    period_reg [CHANNELS];
    logic [WIDTH-1:0]    duty_reg   [CHANNELS];
    logic [WIDTH-1:0]    period_act [CHANNELS];
    logic [WIDTH-1:0]    duty_act   [CHANNELS];
    logic [WIDTH-1:0]    cnt        [CHANNELS];
    logic [WIDTH-1:0]    period_nxt [CHANNELS];
    logic [WIDTH-1:0]    duty_nxt   [CHANNELS];

    logic wr_ctrl;
    logic wr_prescale;
    logic sync;
    logic tick;

    assign wr_ctrl     = wr_en && (wr_addr == 7'h00);
    assign wr_prescale = wr_en && (wr_addr == 7'h01);
    assign sync        = wr_ctrl && wr_data[7];
    assign tick        = (pcnt == prescale);

    // Post-write register values; SYNC reloads shadows from these.
    always_comb begin
        for (int n = 0; n < CHANNELS; n++) begin
            period_nxt[n] = period_reg[n];
            duty_nxt[n]   = duty_reg[n];
            if (wr_en && (wr_addr == 7'(2 + 2 * n)))
                period_nxt[n] = wr_data;
            if (wr_en && (wr_addr == 7'(3 + 2 * n)))
                duty_nxt[n] = wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_addr == 7'h00)
            rd_data[CHANNELS-1:0] = enable;
        else if (rd_addr == 7'h01)
            rd_data = prescale;
        for (int n = 0; n < CHANNELS; n++) begin
            if (rd_addr == 7'(2 + 2 * n))
                rd_data = period_reg[n];
            if (rd_addr == 7'(3 + 2 * n))
                rd_data = duty_reg[n];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable     <= '0;
            prescale   <= '0;
            pcnt       <= '0;
            pwm_out    <= '0;
            period_end <= '0;
            for (int n = 0; n < CHANNELS; n++) begin
                period_reg[n] <= '1;
                duty_reg[n]   <= '0;
                period_act[n] <= '1;
                duty_act[n]   <= '0;
                cnt[n]        <= '0;
            end
        end else begin
            if (wr_ctrl)
                enable <= wr_data[CHANNELS-1:0];
            if (wr_prescale)
                prescale <= wr_data;
            pcnt <= (sync || tick) ? '0 : pcnt + WIDTH'(1);

            for (int n = 0; n < CHANNELS; n++) begin
                period_reg[n] <= period_nxt[n];
                duty_reg[n]   <= duty_nxt[n];
                pwm_out[n]    <= enable[n] && (cnt[n] < duty_act[n]);
                period_end[n] <= 1'b0;

                // SYNC outranks a wrap and never produces a period_end pulse.
                if (sync) begin
                    cnt[n]        <= '0;
                    period_act[n] <= period_nxt[n];
                    duty_act[n]   <= duty_nxt[n];
                end else if (!enable[n]) begin
                    cnt[n]        <= '0;
                    period_act[n] <= period_reg[n];
                    duty_act[n]   <= duty_reg[n];
                end else if (tick) begin
                    if (cnt[n] == period_act[n]) begin
                        cnt[n]        <= '0;
                        period_act[n] <= period_reg[n];
                        duty_act[n]   <= duty_reg[n];
                        period_end[n] <= 1'b1;
                    end else begin
                        cnt[n] <= cnt[n] + WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule

// File: doc/pwm_reg_bank.md
Name: pwm_reg_bank

Overview:
- Downstream consumer of the SPI register slave's write port.
- Holds the PWM configuration registers and generates CHANNELS double-buffered PWM outputs on the system clock.
- Provides combinational readback so the SPI slave can return register contents.
- All register writes arrive as single-cycle strobes already in the clk domain.

Parameters:
- CHANNELS, 2, number of PWM channels (1..4).
- WIDTH, 8, period/duty counter width; fixed equal to the SPI data width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- wr_en  input  1  single-cycle write strobe from the SPI slave.
- wr_addr  input  7  register address; MSB read flag already stripped.
- wr_data  input  8  write data.
- rd_addr  input  7  readback address.
- rd_data  output  8  readback data, combinational from rd_addr.
- pwm_out  output  CHANNELS  registered PWM outputs.
- period_end  output  CHANNELS  one-cycle pulse per channel on counter wrap.

Behaviour:
- Register map:
  - 0x00 CTRL: bits[CHANNELS-1:0] are channel enables; bit7 is SYNC, write-1 self-clearing, always reads 0.
  - 0x01 PRESCALE.
  - 0x02+2*n PERIOD[n].
  - 0x03+2*n DUTY[n].
  - Other addresses: writes ignored, reads return 0x00.
- Reset values (rst=1 at clk edge):
  - CTRL=0x00, PRESCALE=0x00, all PERIOD=0xFF, all DUTY=0x00.
  - Shadow (active) period/duty take the same values.
  - Prescaler and all channel counters = 0.
  - pwm_out=0, period_end=0.
- Reset mid-operation: all of the above restored on the next edge; an in-flight write in the same cycle is discarded.
- Writes: register updates on the edge where wr_en=1. Readback returns the written (programmed) value, not the shadow value.
- Prescaler:
  - pcnt counts 0..PRESCALE.
  - tick=1 when pcnt==PRESCALE, then pcnt returns to 0.
  - PRESCALE=0 gives tick every clk.
  - A PRESCALE write takes effect on the next comparison (no shadow).
- Channel n, enabled:
  - On tick: if cnt==period_act, cnt<=0, period_act<=PERIOD[n], duty_act<=DUTY[n], and period_end[n] pulses high on the following cycle for exactly one clk; else cnt<=cnt+1.
  - Output cycle length is (period_act+1) ticks.
- Channel n, disabled:
  - cnt held at 0, pwm_out[n]=0, period_end[n]=0.
  - Shadows load PERIOD/DUTY every cycle, so enabling starts with the latest values.
- Output: pwm_out[n] <= enable[n] && (cnt < duty_act), registered, one clk latency after cnt changes.
  - duty_act=0 gives a constant 0.
  - duty_act > period_act gives a constant 1.
- Simultaneous events:
  - PERIOD/DUTY write on the same edge as a wrap: shadow loads the pre-write value; the new value applies from the following wrap.
  - SYNC write: all channel counters and pcnt <= 0 and all shadows reload on the next edge. If another write lands on that same edge, shadows load the post-write register values. SYNC has priority over a wrap on the same edge; no period_end pulse is generated for a SYNC.
  - Enable cleared mid-period: output goes low on the next registered update; counter resets to 0.
- Widths: counters are WIDTH bits; no overflow is possible since cnt <= period_act <= 2^WIDTH-1.

Test Plan:
- Reset: assert rst 2 cycles -> pwm_out=0, period_end=0; reading rd_addr 0x00/0x01/0x02/0x03 gives 0x00/0x00/0xFF/0x00.
- Basic PWM: write PERIOD0=9, DUTY0=3, PRESCALE=0, then CTRL=0x01 -> pwm_out[0] repeats 3 clk high / 7 clk low; period_end[0] pulses every 10 clk.
- Prescale: PRESCALE=1, PERIOD0=3, DUTY0=2 -> pwm_out[0] is 4 clk high / 4 clk low, period 8 clk.
- Double buffering: while running PERIOD0=9, DUTY0=3, write DUTY0=7 mid-period -> the current period keeps 3 high; the next period has 7 high; DUTY0 written on the wrap edge itself takes effect one period later.
- Boundaries: DUTY0=0 -> constant 0; DUTY0=10 with PERIOD0=9 -> constant 1; unmapped address 0x7F write is ignored and reads 0x00.
- SYNC/reset mid-run: two channels with different phase; write CTRL=0x83 -> both counters restart aligned, rising edges coincide, CTRL reads 0x03; asserting rst mid-period -> outputs 0 next edge and registers return to reset values.
